// File: rtl/lemon_lsu.sv
// Load/store unit: turns one decoded memory request into a single valid/ready bus access.
// It stalls the core while the access is in flight, aligns store data and strobes, and extends load data.
module lemon_lsu #(
  parameter int TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [7:0]  mem_mask,
  input  logic        ld_signed,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  output logic        stall,
  output logic        done,
  output logic        err,
  output logic [63:0] rdata,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic        bus_we,
  output logic [63:0] bus_addr,
  output logic [7:0]  bus_wstrb,
  output logic [63:0] bus_wdata,
  input  logic        bus_rvalid,
  input  logic [63:0] bus_rdata
);

  // state | meaning
  // IDLE  | waiting for a request; the cycle after a rejected request or a timeout carries the err pulse
  // REQ   | bus_valid high, waiting for bus_ready
  // RESP  | read accepted, waiting for bus_rvalid
  // DONE  | done pulse, rdata valid for loads
  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t      state;
  logic [7:0]  tmo_cnt;
  logic [2:0]  off_q;
  logic [7:0]  mask_q;
  logic        signed_q;

  logic        req;
  logic        accept;
  logic        bad_req;
  logic        tmo_last;
  logic [15:0] wide_strb;
  logic [63:0] lane;
  logic [63:0] ext;

  always_comb begin
    req       = mem_ren | mem_wen;
    // The err cycle is still IDLE; the held request must not be taken again there.
    accept    = (state == IDLE) && req && !err;
    wide_strb = {8'h00, mem_mask} << addr[2:0];
    bad_req   = (|wide_strb[15:8]) | (mem_ren & mem_wen);
    stall     = accept || (state == REQ) || (state == RESP);
    tmo_last  = (tmo_cnt == 8'd0);
  end

  always_comb begin
    lane = bus_rdata >> {off_q, 3'b000};
    case (mask_q)
      8'h01:   ext = {{56{signed_q & lane[7]}},  lane[7:0]};
      8'h03:   ext = {{48{signed_q & lane[15]}}, lane[15:0]};
      8'h0F:   ext = {{32{signed_q & lane[31]}}, lane[31:0]};
      default: ext = lane;
    endcase
  end

  // Timeout is a down-counter loaded on IDLE exit; terminal count on the last allowed cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tmo_cnt   <= 8'd0;
      off_q     <= 3'd0;
      mask_q    <= 8'd0;
      signed_q  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      rdata     <= 64'd0;
      bus_valid <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 64'd0;
      bus_wstrb <= 8'd0;
      bus_wdata <= 64'd0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            tmo_cnt <= 8'(TIMEOUT - 1);
            if (bad_req) begin
              err <= 1'b1;
            end else begin
              state     <= REQ;
              bus_valid <= 1'b1;
              bus_we    <= mem_wen;
              bus_addr  <= {addr[63:3], 3'b000};
              bus_wstrb <= wide_strb[7:0];
              bus_wdata <= wdata << {addr[2:0], 3'b000};
              off_q     <= addr[2:0];
              mask_q    <= mem_mask;
              signed_q  <= ld_signed;
            end
          end
        end
        REQ: begin
          if (!tmo_last) tmo_cnt <= tmo_cnt - 8'd1;
          if (bus_ready) begin
            bus_valid <= 1'b0;
            if (bus_we) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RESP;
            end
          end else if (tmo_last) begin
            bus_valid <= 1'b0;
            err       <= 1'b1;
            state     <= IDLE;
          end
        end
        RESP: begin
          if (!tmo_last) tmo_cnt <= tmo_cnt - 8'd1;
          if (bus_rvalid) begin
            rdata <= ext;
            done  <= 1'b1;
            state <= DONE;
          end else if (tmo_last) begin
            err   <= 1'b1;
            state <= IDLE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lemon_lsu.sv
// Directed bench for lemon_lsu: a vector table of single accesses plus hand-written
// sequences for backpressure, timeout and reset in the middle of a load.
module tb_lemon_lsu;

  logic        clk;
  logic        rst;
  logic        mem_ren;
  logic        mem_wen;
  logic [7:0]  mem_mask;
  logic        ld_signed;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic        stall;
  logic        done;
  logic        err;
  logic [63:0] rdata;
  logic        bus_valid;
  logic        bus_ready;
  logic        bus_we;
  logic [63:0] bus_addr;
  logic [7:0]  bus_wstrb;
  logic [63:0] bus_wdata;
  logic        bus_rvalid;
  logic [63:0] bus_rdata;

  int total = 0;
  int bad   = 0;

  lemon_lsu #(.TIMEOUT(256)) dut (
    .clk(clk), .rst(rst),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_mask(mem_mask), .ld_signed(ld_signed),
    .addr(addr), .wdata(wdata),
    .stall(stall), .done(done), .err(err), .rdata(rdata),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ren;
    logic        wen;
    logic        sgn;
    logic [7:0]  mask;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] brd;
    logic [63:0] exp_addr;
    logic [7:0]  exp_strb;
    logic [63:0] exp_wdata;
    logic [63:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  localparam int NV = 13;
  vec_t vt [NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    mem_ren = 0; mem_wen = 0; mem_mask = 0; ld_signed = 0; addr = 0; wdata = 0;
    bus_ready = 0; bus_rvalid = 0; bus_rdata = 0;
  endtask

  // One access with ready=1 and rvalid one cycle after the read handshake.
  task automatic run_vec(input vec_t v, input string tag);
    bit seen_v;
    bit fin;
    int lat;
    @(posedge clk); #1;
    mem_ren = v.ren; mem_wen = v.wen; mem_mask = v.mask; ld_signed = v.sgn;
    addr = v.addr; wdata = v.wdata;
    bus_ready = 1; bus_rvalid = 0; bus_rdata = v.brd;
    seen_v = 0; fin = 0; lat = -1;
    @(negedge clk);
    chk($sformatf("%s.stall_req", tag), stall, 1);
    for (int c = 1; c <= 20 && !fin; c++) begin
      @(posedge clk); #1;
      if (seen_v && v.ren && !v.wen) bus_rvalid = 1;
      @(negedge clk);
      if (bus_valid) begin
        seen_v = 1;
        chk($sformatf("%s.bus_addr", tag), bus_addr, v.exp_addr);
        chk($sformatf("%s.bus_wstrb", tag), bus_wstrb, v.exp_strb);
        chk($sformatf("%s.bus_we", tag), bus_we, v.wen);
        if (v.wen) chk($sformatf("%s.bus_wdata", tag), bus_wdata, v.exp_wdata);
      end
      if (done || err) begin
        fin = 1;
        lat = c;
        chk($sformatf("%s.stall_end", tag), stall, 0);
        chk($sformatf("%s.err", tag), err, v.exp_err);
        chk($sformatf("%s.done", tag), done, !v.exp_err);
        if (v.ren && !v.wen && !v.exp_err) chk($sformatf("%s.rdata", tag), rdata, v.exp_rdata);
      end else begin
        chk($sformatf("%s.stall_mid", tag), stall, 1);
      end
    end
    chk($sformatf("%s.latency", tag), 64'(lat), 64'(v.exp_lat));
    chk($sformatf("%s.bus_used", tag), seen_v, !v.exp_err);
    @(posedge clk); #1;
    idle_inputs();
  endtask

  initial begin : watchdog
    #200us;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int n_done;
    int tcyc;
    bit hit;
    vec_t sd2;

    //          ren wen sgn mask   addr                  wdata                  brd                    exp_addr              strb   exp_wdata              exp_rdata              err lat
    vt[0]  = '{0, 1, 0, 8'hFF, 64'h0000_0000_8000_0008, 64'h1122334455667788, 64'h0,                64'h0000_0000_8000_0008, 8'hFF, 64'h1122334455667788, 64'h0,                0, 2};
    vt[1]  = '{0, 1, 0, 8'h01, 64'h0000_0000_8000_0005, 64'h00000000000000AB, 64'h0,                64'h0000_0000_8000_0000, 8'h20, 64'h0000AB0000000000, 64'h0,                0, 2};
    vt[2]  = '{1, 0, 1, 8'h03, 64'h0000_0000_8000_0002, 64'h0,                64'h0000000080F10000, 64'h0000_0000_8000_0000, 8'h0C, 64'h0,                64'hFFFFFFFFFFFF80F1, 0, 3};
    vt[3]  = '{1, 0, 0, 8'h03, 64'h0000_0000_8000_0002, 64'h0,                64'h0000000080F10000, 64'h0000_0000_8000_0000, 8'h0C, 64'h0,                64'h00000000000080F1, 0, 3};
    vt[4]  = '{0, 1, 0, 8'h0F, 64'h0000_0000_8000_0006, 64'h0000000012345678, 64'h0,                64'h0,                   8'h00, 64'h0,                64'h0,                1, 1};
    vt[5]  = '{1, 0, 1, 8'h01, 64'h0000_0000_8000_0007, 64'h0,                64'h8000000000000000, 64'h0000_0000_8000_0000, 8'h80, 64'h0,                64'hFFFFFFFFFFFFFF80, 0, 3};
    vt[6]  = '{1, 0, 0, 8'h0F, 64'h0000_0000_8000_0004, 64'h0,                64'hDEADBEEF12345678, 64'h0000_0000_8000_0000, 8'hF0, 64'h0,                64'h00000000DEADBEEF, 0, 3};
    vt[7]  = '{1, 0, 1, 8'h0F, 64'h0000_0000_8000_0004, 64'h0,                64'hDEADBEEF12345678, 64'h0000_0000_8000_0000, 8'hF0, 64'h0,                64'hFFFFFFFFDEADBEEF, 0, 3};
    vt[8]  = '{1, 0, 1, 8'hFF, 64'h0000_0000_8000_0010, 64'h0,                64'h0123456789ABCDEF, 64'h0000_0000_8000_0010, 8'hFF, 64'h0,                64'h0123456789ABCDEF, 0, 3};
    vt[9]  = '{0, 1, 0, 8'h03, 64'h0000_0000_8000_0006, 64'h000000000000BEEF, 64'h0,                64'h0000_0000_8000_0000, 8'hC0, 64'hBEEF000000000000, 64'h0,                0, 2};
    vt[10] = '{1, 1, 0, 8'hFF, 64'h0000_0000_8000_0000, 64'h0,                64'h0,                64'h0,                   8'h00, 64'h0,                64'h0,                1, 1};
    vt[11] = '{0, 1, 0, 8'h03, 64'h0000_0000_8000_0007, 64'h000000000000BEEF, 64'h0,                64'h0,                   8'h00, 64'h0,                64'h0,                1, 1};
    vt[12] = '{1, 0, 0, 8'hFF, 64'h0000_0000_8000_0001, 64'h0,                64'h0,                64'h0,                   8'h00, 64'h0,                64'h0,                1, 1};

    idle_inputs();
    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.stall", stall, 0);
    chk("rst.done", done, 0);
    chk("rst.err", err, 0);
    chk("rst.bus_valid", bus_valid, 0);
    chk("rst.bus_we", bus_we, 0);
    chk("rst.rdata", rdata, 0);
    chk("rst.bus_addr", bus_addr, 0);
    chk("rst.bus_wstrb", bus_wstrb, 0);
    chk("rst.bus_wdata", bus_wdata, 0);
    @(posedge clk); #1;
    rst = 0;

    for (int i = 0; i < NV; i++) run_vec(vt[i], $sformatf("v%0d", i));

    // Backpressure: ready low for 10 cycles, fields must hold, exactly one done.
    @(posedge clk); #1;
    mem_wen = 1; mem_mask = 8'hFF; addr = 64'h0000_0000_8000_0018; wdata = 64'hCAFEF00D0BADBEEF;
    bus_ready = 0;
    n_done = 0;
    @(negedge clk);
    chk("bp.stall_req", stall, 1);
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("bp.valid%0d", k), bus_valid, 1);
      chk($sformatf("bp.addr%0d", k), bus_addr, 64'h0000_0000_8000_0018);
      chk($sformatf("bp.wdata%0d", k), bus_wdata, 64'hCAFEF00D0BADBEEF);
      chk($sformatf("bp.strb%0d", k), bus_wstrb, 8'hFF);
      chk($sformatf("bp.stall%0d", k), stall, 1);
      if (done) n_done++;
    end
    @(posedge clk); #1;
    bus_ready = 1;
    @(negedge clk);
    chk("bp.valid_hs", bus_valid, 1);
    if (done) n_done++;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp.done", done, 1);
    chk("bp.stall_done", stall, 0);
    if (done) n_done++;
    @(posedge clk); #1;
    idle_inputs();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done) n_done++;
      @(posedge clk); #1;
    end
    chk("bp.done_count", 64'(n_done), 1);

    // Timeout: ready never comes; err expected 257 cycles after the request cycle.
    mem_ren = 1; mem_mask = 8'hFF; addr = 64'h0000_0000_8000_0020;
    bus_ready = 0;
    tcyc = -1;
    hit = 0;
    for (int c = 1; c <= 400 && !hit; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (c == 256) chk("tmo.valid_last", bus_valid, 1);
      if (err) begin
        hit = 1;
        tcyc = c;
        chk("tmo.valid_drop", bus_valid, 0);
        chk("tmo.stall", stall, 0);
        chk("tmo.done", done, 0);
      end
    end
    chk("tmo.cycle", 64'(tcyc), 64'd257);
    @(posedge clk); #1;
    idle_inputs();
    bus_rvalid = 1; bus_rdata = 64'h5555AAAA5555AAAA;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("tmo.late_done%0d", k), done, 0);
      chk($sformatf("tmo.late_stall%0d", k), stall, 0);
      @(posedge clk); #1;
    end
    idle_inputs();

    // Reset while waiting in RESP.
    mem_ren = 1; mem_mask = 8'hFF; addr = 64'h0000_0000_8000_0008; bus_ready = 1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mrst.hs_valid", bus_valid, 1);
    @(posedge clk); #1;
    bus_ready = 0;
    @(negedge clk);
    chk("mrst.resp_stall", stall, 1);
    chk("mrst.resp_valid", bus_valid, 0);
    @(posedge clk); #1;
    rst = 1;
    mem_ren = 0;
    @(posedge clk); #1;
    rst = 0;
    bus_rvalid = 1; bus_rdata = 64'h1;
    @(negedge clk);
    chk("mrst.stall", stall, 0);
    chk("mrst.done", done, 0);
    chk("mrst.err", err, 0);
    chk("mrst.valid", bus_valid, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mrst.done_after", done, 0);
    @(posedge clk); #1;
    idle_inputs();

    sd2 = vt[0];
    run_vec(sd2, "post_rst_sd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
